eff_clip_ctrl: RTL and testbench

EFF_CLIP_CTRL -- requirements
Module: eff_clip_ctrl

---
 rtl/eff_clip_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_eff_clip_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eff_clip_ctrl.sv
// -----------------------------------------------------------------------------
// eff_clip_ctrl -- on/off and gain controller for the clip effect stage.
//
// Tracks a user-set target gain (up/down buttons, saturating 1..2^GAIN_WIDTH-1)
// and drives the clip stage enable and applied gain. When the effect is
// switched on or off, the applied gain ramps one step every RAMP_DIV audio
// sample strobes, so the effect fades in and out without clicks.
//
// Build option:
//   EFF_CLIP_CTRL_RAMP_EN  defined   -> ramped fades (FADE_IN / FADE_OUT used)
//                          undefined -> instant on/off, gain follows target,
//                                       busy_o tied low, no divider logic
//
// Parameters:
//   GAIN_WIDTH  width of gain_o / target_o
//   GAIN_INIT   target gain after reset (1..2^GAIN_WIDTH-1)
//   RAMP_DIV    vld_i strobes per one-step gain change (>= 1)
//
// Ports:
//   clk       clock, all logic on posedge
//   rst       synchronous active-high reset
//   toggle_i  pulse: toggle effect on/off
//   up_i      pulse: increment target gain
//   down_i    pulse: decrement target gain
//   vld_i     audio sample strobe (ramp time base)
//   en_o      effect enable (registered)
//   gain_o    applied gain (registered)
//   busy_o    ramp in progress (registered)
//   target_o  target gain for the display (registered)
// -----------------------------------------------------------------------------
module eff_clip_ctrl #(
    parameter int GAIN_WIDTH = 6,
    parameter int GAIN_INIT  = 8,
    parameter int RAMP_DIV   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  toggle_i,
    input  logic                  up_i,
    input  logic                  down_i,
    input  logic                  vld_i,
    output logic                  en_o,
    output logic [GAIN_WIDTH-1:0] gain_o,
    output logic                  busy_o,
    output logic [GAIN_WIDTH-1:0] target_o
);

    typedef enum logic [1:0] {
        BYPASS   = 2'd0,
        FADE_IN  = 2'd1,
        ACTIVE   = 2'd2,
        FADE_OUT = 2'd3
    } state_t;

    localparam logic [GAIN_WIDTH-1:0] GAIN_MAX = '1;
    localparam logic [GAIN_WIDTH-1:0] GAIN_ONE = GAIN_WIDTH'(1);
    localparam logic [GAIN_WIDTH-1:0] GAIN_RST = GAIN_WIDTH'(GAIN_INIT);

    state_t                  state_reg, state_next;
    logic [GAIN_WIDTH-1:0]   gain_reg, gain_next;
    logic [GAIN_WIDTH-1:0]   target_reg, target_next;
    logic                    en_reg, en_next;

    // -------------------------------------------------------------------------
    // Target gain: saturating up/down; simultaneous up and down cancel.
    // -------------------------------------------------------------------------
    always_comb begin
        target_next = target_reg;
        if (up_i && !down_i && (target_reg != GAIN_MAX)) begin
            target_next = target_reg + GAIN_ONE;
        end else if (down_i && !up_i && (target_reg != GAIN_ONE)) begin
            target_next = target_reg - GAIN_ONE;
        end
    end

`ifdef EFF_CLIP_CTRL_RAMP_EN
    // -------------------------------------------------------------------------
    // Ramped build.
    // -------------------------------------------------------------------------
    localparam int                DIV_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(RAMP_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0]      div_reg, div_next;
    logic                  busy_reg, busy_next;
    logic [GAIN_WIDTH-1:0] goal;

    always_comb begin
        state_next = state_reg;
        gain_next  = gain_reg;
        div_next   = div_reg;

        // Fading in or sitting active heads for the target; everything else
        // heads for unity.
        if ((state_reg == FADE_IN) || (state_reg == ACTIVE)) begin
            goal = target_reg;
        end else begin
            goal = GAIN_ONE;
        end

        // Sample-rate time base. Frozen when no strobes arrive.
        if ((state_reg != BYPASS) && vld_i) begin
            if (div_reg == DIV_LAST) begin
                div_next = '0;
                if (gain_reg < goal) begin
                    gain_next = gain_reg + GAIN_ONE;
                end else if (gain_reg > goal) begin
                    gain_next = gain_reg - GAIN_ONE;
                end
            end else begin
                div_next = div_reg + DIV_ONE;
            end
        end

        // A toggle restarts the divider and freezes gain for that edge, so a
        // reversed fade always starts from the gain currently applied.
        case (state_reg)
            BYPASS: begin
                gain_next = GAIN_ONE;
                div_next  = '0;
                if (toggle_i) begin
                    state_next = FADE_IN;
                end
            end
            FADE_IN: begin
                if (toggle_i) begin
                    state_next = FADE_OUT;
                    gain_next  = gain_reg;
                    div_next   = '0;
                end else if (gain_reg == target_reg) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (toggle_i) begin
                    state_next = FADE_OUT;
                    gain_next  = gain_reg;
                    div_next   = '0;
                end
            end
            FADE_OUT: begin
                if (toggle_i) begin
                    state_next = FADE_IN;
                    gain_next  = gain_reg;
                    div_next   = '0;
                end else if (gain_reg == GAIN_ONE) begin
                    state_next = BYPASS;
                    div_next   = '0;
                end
            end
            default: begin
                state_next = BYPASS;
                gain_next  = GAIN_ONE;
                div_next   = '0;
            end
        endcase

        en_next   = (state_next != BYPASS);
        // Registered busy reflects the state/gain/target being loaded now.
        busy_next = (state_next == FADE_IN) || (state_next == FADE_OUT) ||
                    ((state_next == ACTIVE) && (gain_next != target_next));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg  <= '0;
            busy_reg <= 1'b0;
        end else begin
            div_reg  <= div_next;
            busy_reg <= busy_next;
        end
    end

    assign busy_o = busy_reg;

`else
    // -------------------------------------------------------------------------
    // Instant build: no divider, gain follows target while active.
    // -------------------------------------------------------------------------
    logic unused_vld;
    assign unused_vld = vld_i;

    always_comb begin
        state_next = state_reg;
        gain_next  = gain_reg;
        case (state_reg)
            BYPASS: begin
                gain_next = GAIN_ONE;
                if (toggle_i) begin
                    state_next = ACTIVE;
                    gain_next  = target_next;
                end
            end
            ACTIVE: begin
                gain_next = target_next;
                if (toggle_i) begin
                    state_next = BYPASS;
                    gain_next  = GAIN_ONE;
                end
            end
            default: begin
                state_next = BYPASS;
                gain_next  = GAIN_ONE;
            end
        endcase
        en_next = (state_next != BYPASS);
    end

    assign busy_o = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Shared state and output registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= BYPASS;
            gain_reg   <= GAIN_ONE;
            target_reg <= GAIN_RST;
            en_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            gain_reg   <= gain_next;
            target_reg <= target_next;
            en_reg     <= en_next;
        end
    end

    assign en_o     = en_reg;
    assign gain_o   = gain_reg;
    assign target_o = target_reg;

endmodule

// File: tb/tb_eff_clip_ctrl.sv
// -----------------------------------------------------------------------------
// tb_eff_clip_ctrl -- scoreboard bench for eff_clip_ctrl.
// The stimulus thread advances a behavioural model and queues the expected
// outputs for every clock; a monitor on the falling edge pops and compares.
// Works for both builds (EFF_CLIP_CTRL_RAMP_EN defined or not).
// -----------------------------------------------------------------------------
module tb_eff_clip_ctrl;

    localparam int GW   = 6;
    localparam int INIT = 8;
    localparam int DIV  = 4;
    localparam int GMAX = (1 << GW) - 1;

    // model modes
    localparam int M_OFF  = 0;
    localparam int M_RISE = 1;
    localparam int M_ON   = 2;
    localparam int M_FALL = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          toggle_i = 1'b0;
    logic          up_i = 1'b0;
    logic          down_i = 1'b0;
    logic          vld_i = 1'b0;
    logic          en_o;
    logic [GW-1:0] gain_o;
    logic          busy_o;
    logic [GW-1:0] target_o;

    eff_clip_ctrl #(
        .GAIN_WIDTH (GW),
        .GAIN_INIT  (INIT),
        .RAMP_DIV   (DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .toggle_i (toggle_i),
        .up_i     (up_i),
        .down_i   (down_i),
        .vld_i    (vld_i),
        .en_o     (en_o),
        .gain_o   (gain_o),
        .busy_o   (busy_o),
        .target_o (target_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic          busy;
        logic [GW-1:0] gain;
        logic [GW-1:0] target;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_cyc = 0;

    // behavioural model state
    int m_mode   = M_OFF;
    int m_gain   = 1;
    int m_target = INIT;
    int m_pulses = 0;   // vld strobes seen since the last restart of the fade clock

    task automatic model_step(input bit tog, input bit up, input bit dn,
                              input bit vld, input bit r);
        exp_t e;
        int   new_target;
        int   goal;
        bit   busy;
        if (r) begin
            m_mode = M_OFF; m_gain = 1; m_target = INIT; m_pulses = 0;
            busy = 0;
        end else begin
            new_target = m_target;
            if (up && !dn)  new_target = (m_target < GMAX) ? m_target + 1 : GMAX;
            if (dn && !up)  new_target = (m_target > 1) ? m_target - 1 : 1;
`ifdef EFF_CLIP_CTRL_RAMP_EN
            goal = (m_mode == M_RISE || m_mode == M_ON) ? m_target : 1;
            if (tog) begin
                m_pulses = 0;
                case (m_mode)
                    M_OFF:   begin m_mode = M_RISE; m_gain = 1; end
                    M_RISE:  m_mode = M_FALL;
                    M_ON:    m_mode = M_FALL;
                    default: m_mode = M_RISE;
                endcase
            end else if (m_mode == M_OFF) begin
                m_gain = 1; m_pulses = 0;
            end else begin
                int old_gain;
                old_gain = m_gain;
                if (vld) begin
                    m_pulses = m_pulses + 1;
                    if (m_pulses == DIV) begin
                        m_pulses = 0;
                        if (m_gain < goal) m_gain = m_gain + 1;
                        else if (m_gain > goal) m_gain = m_gain - 1;
                    end
                end
                if (m_mode == M_RISE && old_gain == m_target) m_mode = M_ON;
                else if (m_mode == M_FALL && old_gain == 1) begin
                    m_mode = M_OFF; m_pulses = 0;
                end
            end
            busy = (m_mode == M_RISE) || (m_mode == M_FALL) ||
                   ((m_mode == M_ON) && (m_gain != new_target));
`else
            goal = 0;
            if (tog) begin
                if (m_mode == M_OFF) begin m_mode = M_ON; m_gain = new_target; end
                else begin m_mode = M_OFF; m_gain = 1; end
            end else if (m_mode == M_ON) begin
                m_gain = new_target;
            end
            busy = 0;
            if (goal != 0 || vld) busy = 0;
`endif
            m_target = new_target;
        end
        e.en     = (m_mode != M_OFF);
        e.busy   = busy;
        e.gain   = GW'(m_gain);
        e.target = GW'(m_target);
        q.push_back(e);
    endtask

    // One clock of stimulus: drive, predict, advance past the edge.
    task automatic cyc(input bit tog, input bit up, input bit dn,
                       input bit vld, input bit r);
        rst = r; toggle_i = tog; up_i = up; down_i = dn; vld_i = vld;
        model_step(tog, up, dn, vld, r);
        @(posedge clk);
        #2;
        n_cyc++;
    endtask

    task automatic idle(input int n, input bit vld);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, vld, 0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare each against the queue.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            if ({en_o, busy_o, gain_o, target_o} !== {e.en, e.busy, e.gain, e.target}) begin
                n_bad++;
                $display("FAIL scoreboard: got en=%0b busy=%0b gain=%0d target=%0d, required en=%0b busy=%0b gain=%0d target=%0d (t=%0t)",
                         en_o, busy_o, gain_o, target_o, e.en, e.busy, e.gain, e.target, $time);
            end
        end
    end

    initial begin
        int start;
        // ---- reset ----
        cyc(0, 1, 0, 1, 1);
        cyc(1, 0, 0, 1, 1);
        chk("reset_en", en_o, 0);
        chk("reset_gain", gain_o, 1);
        chk("reset_target", target_o, INIT);
        chk("reset_busy", busy_o, 0);
        $display("txn reset: cycles=%0d", n_cyc);

        // ---- fade in ----
        start = n_cyc;
        cyc(1, 0, 0, 1, 0);
        chk("on_en", en_o, 1);
`ifdef EFF_CLIP_CTRL_RAMP_EN
        chk("on_gain_start", gain_o, 1);
        idle(3, 1);
        chk("on_gain_3p", gain_o, 1);
        idle(1, 1);
        chk("on_gain_4p", gain_o, 2);
        idle(24, 1);
        chk("on_gain_28p", gain_o, 8);
        chk("on_busy_28p", busy_o, 1);
        idle(1, 1);
        chk("on_busy_done", busy_o, 0);
`else
        chk("on_gain", gain_o, INIT);
        chk("on_busy", busy_o, 0);
        idle(30, 1);
        chk("on_busy_idle", busy_o, 0);
`endif
        $display("txn fade_in: cycles=%0d", n_cyc - start);

        // ---- fade out ----
        start = n_cyc;
        idle(3, 1);
        cyc(1, 0, 0, 1, 0);
`ifdef EFF_CLIP_CTRL_RAMP_EN
        idle(28, 1);
        chk("off_gain_28p", gain_o, 1);
        chk("off_en_28p", en_o, 1);
        idle(1, 1);
        chk("off_en_after", en_o, 0);
`else
        chk("off_en", en_o, 0);
        chk("off_gain", gain_o, 1);
`endif
        $display("txn fade_out: cycles=%0d", n_cyc - start);

        // ---- target saturation ----
        start = n_cyc;
        for (int i = 0; i < 70; i++) cyc(0, 1, 0, i[0], 0);
        chk("sat_up", target_o, GMAX);
        for (int i = 0; i < 70; i++) cyc(0, 0, 1, i[0], 0);
        chk("sat_down", target_o, 1);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        chk("up_down_same", target_o, 2);
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0);
        chk("back_to_8", target_o, 8);
        $display("txn saturation: cycles=%0d", n_cyc - start);

        // ---- reversal mid-fade ----
        start = n_cyc;
        cyc(1, 0, 0, 1, 0);
        for (int i = 0; i < 60 && m_gain != 5; i++) idle(1, 1);
        cyc(1, 0, 0, 1, 0);
        for (int i = 0; i < 60 && m_gain != 3; i++) idle(1, 1);
        cyc(1, 0, 0, 1, 0);
        idle(30, 1);
        chk("reverse_gain", gain_o, 8);
        $display("txn reversal: cycles=%0d", n_cyc - start);

        // ---- reset mid-ramp ----
        start = n_cyc;
        cyc(1, 0, 0, 1, 0);
        for (int i = 0; i < 60 && m_gain != 6; i++) idle(1, 1);
        cyc(1, 1, 0, 1, 1);
        chk("mid_rst_en", en_o, 0);
        chk("mid_rst_gain", gain_o, 1);
        chk("mid_rst_target", target_o, 8);
        chk("mid_rst_busy", busy_o, 0);
        cyc(1, 0, 0, 1, 0);
        idle(10, 1);
        $display("txn mid_reset: cycles=%0d", n_cyc - start);

        // ---- randomized traffic ----
        start = n_cyc;
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 59) == 0),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 499) == 0));
        end
        $display("txn random: cycles=%0d", n_cyc - start);

        // let the monitor drain the last expectation
        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
